// File: rtl/sample_stream_packetizer.sv
// sample_stream_packetizer: FIFO-buffered sample stream framed into fixed-length Avalon-ST packets with zero-pad flush
module sample_stream_packetizer #(
    parameter int DATA_W     = 32,
    parameter int PKT_LEN    = 96,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_enable,
    input  logic                          i_clr_status,
    input  logic [DATA_W-1:0]             asi_data,
    input  logic                          asi_valid,
    output logic [DATA_W-1:0]             aso_data,
    output logic                          aso_valid,
    input  logic                          aso_ready,
    output logic                          aso_startofpacket,
    output logic                          aso_endofpacket,
    output logic                          o_overflow,
    output logic [CNT_W-1:0]              o_drop_count,
    output logic [CNT_W-1:0]              o_pkt_count,
    output logic [$clog2(FIFO_DEPTH):0]   o_fill
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(PKT_LEN);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
    state_t state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [BW-1:0] beat, beat_next;
    logic xfer, out_free, empty, push_req, pop, bypass, pad, wr, drop, last, idle_ok;
    assign xfer      = aso_valid && aso_ready;
    assign out_free  = !aso_valid || aso_ready;
    assign empty     = o_fill == '0;
    assign last      = beat == LAST;
    assign beat_next = xfer ? (last ? '0 : beat + BW'(1)) : beat;
    assign push_req  = state == STREAM && asi_valid;
    assign pop       = out_free && !empty;
    assign bypass    = out_free && empty && push_req;
    assign pad       = out_free && empty && state == FLUSH && beat_next != '0;
    assign wr        = push_req && !bypass && (o_fill != FULL || pop);
    assign drop      = push_req && o_fill == FULL && !pop;
    // Leave only when nothing is buffered, held or arriving, so no partial packet escapes.
    assign idle_ok   = empty && beat == '0 && !aso_valid && !push_req;
    assign aso_startofpacket = aso_valid && beat == '0;
    assign aso_endofpacket   = aso_valid && last;
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= asi_data;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            beat         <= '0;
            aso_data     <= '0;
            aso_valid    <= 1'b0;
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
            o_pkt_count  <= '0;
            o_fill       <= '0;
        end else begin
            state <= state == IDLE   ? (i_enable ? STREAM : IDLE) :
                     state == STREAM ? (i_enable ? STREAM : idle_ok ? IDLE : FLUSH) :
                     (idle_ok ? IDLE : FLUSH);
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            o_fill <= o_fill + (AW+1)'(wr) - (AW+1)'(pop);
            beat <= beat_next;
            if (xfer && last) o_pkt_count <= o_pkt_count + CNT_W'(1);
            if (pop || bypass || pad) begin
                aso_valid <= 1'b1;
                aso_data  <= pop ? mem[rd_ptr] : bypass ? asi_data : '0;
            end else if (xfer) begin
                aso_valid <= 1'b0;
            end
            if (drop) begin
                o_overflow   <= 1'b1;
                o_drop_count <= i_clr_status ? CNT_W'(1) :
                                (&o_drop_count) ? o_drop_count : o_drop_count + CNT_W'(1);
            end else if (i_clr_status) begin
                o_overflow   <= 1'b0;
                o_drop_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sample_stream_packetizer.sv
// tb_sample_stream_packetizer: directed scoreboard bench for sample_stream_packetizer (PKT_LEN=4, FIFO_DEPTH=16)
module tb_sample_stream_packetizer;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic i_enable = 1'b0;
    logic i_clr_status = 1'b0;
    logic [31:0] asi_data = '0;
    logic asi_valid = 1'b0;
    logic [31:0] aso_data;
    logic aso_valid;
    logic aso_ready = 1'b0;
    logic aso_startofpacket, aso_endofpacket, o_overflow;
    logic [15:0] o_drop_count, o_pkt_count;
    logic [4:0] o_fill;
    int checks = 0;
    int failures = 0;
    int exp_beat = 0;
    logic [33:0] sb [$];
    always #5 clk = ~clk;
    sample_stream_packetizer #(.DATA_W(32), .PKT_LEN(4), .FIFO_DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .n_rst(n_rst), .i_enable(i_enable), .i_clr_status(i_clr_status),
        .asi_data(asi_data), .asi_valid(asi_valid), .aso_data(aso_data), .aso_valid(aso_valid),
        .aso_ready(aso_ready), .aso_startofpacket(aso_startofpacket), .aso_endofpacket(aso_endofpacket),
        .o_overflow(o_overflow), .o_drop_count(o_drop_count), .o_pkt_count(o_pkt_count), .o_fill(o_fill)
    );
    always @(negedge clk) begin
        if (n_rst && aso_valid) begin
            if (sb.size() == 0) begin
                if (aso_ready) begin
                    checks++;
                    failures++;
                    $display("FAIL beat: unexpected transfer data=%h sop=%0b eop=%0b", aso_data, aso_startofpacket, aso_endofpacket);
                end
            end else begin
                checks++;
                if ({aso_startofpacket, aso_endofpacket, aso_data} !== sb[0]) begin
                    failures++;
                    $display("FAIL beat: got sop=%0b eop=%0b data=%h expected sop=%0b eop=%0b data=%h",
                             aso_startofpacket, aso_endofpacket, aso_data, sb[0][33], sb[0][32], sb[0][31:0]);
                end
                if (aso_ready) void'(sb.pop_front());
            end
        end
    end
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic expect_beat(input logic [31:0] d);
        sb.push_back({exp_beat == 0, exp_beat == 3, d});
        exp_beat = (exp_beat + 1) % 4;
    endtask
    task automatic pulse(input logic [31:0] d, input bit expected);
        asi_valid = 1'b1;
        asi_data = d;
        if (expected) expect_beat(d);
        tick();
        asi_valid = 1'b0;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    initial begin
        tick(2);
        chk("rst_valid", 32'(aso_valid), 0);
        chk("rst_fill", 32'(o_fill), 0);
        chk("rst_pkt", 32'(o_pkt_count), 0);
        chk("rst_drop", 32'(o_drop_count), 0);
        chk("rst_ovf", 32'(o_overflow), 0);
        n_rst = 1'b1;
        i_enable = 1'b1;
        aso_ready = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) pulse(32'(i), 1'b1);
        tick(4);
        chk("t1_pkt", 32'(o_pkt_count), 2);
        chk("t1_drain", 32'(sb.size()), 0);
        aso_ready = 1'b0;
        for (int i = 1; i <= 20; i++) pulse(32'h100 + 32'(i), i <= 17);
        chk("t2_fill", 32'(o_fill), 16);
        chk("t2_drop", 32'(o_drop_count), 3);
        chk("t2_ovf", 32'(o_overflow), 1);
        aso_ready = 1'b1;
        pulse(32'h200, 1'b1);
        chk("t3_fill", 32'(o_fill), 16);
        chk("t3_drop", 32'(o_drop_count), 3);
        tick(25);
        pulse(32'h201, 1'b1);
        pulse(32'h202, 1'b1);
        tick(4);
        chk("t3_pkt", 32'(o_pkt_count), 7);
        chk("t3_drain", 32'(sb.size()), 0);
        aso_ready = 1'b0;
        for (int i = 1; i <= 17; i++) pulse(32'h300 + 32'(i), 1'b1);
        i_clr_status = 1'b1;
        pulse(32'h312, 1'b0);
        i_clr_status = 1'b0;
        chk("t5_drop_clr", 32'(o_drop_count), 1);
        chk("t5_ovf_clr", 32'(o_overflow), 1);
        i_clr_status = 1'b1;
        tick();
        i_clr_status = 1'b0;
        chk("t5_drop_zero", 32'(o_drop_count), 0);
        chk("t5_ovf_zero", 32'(o_overflow), 0);
        aso_ready = 1'b1;
        tick(20);
        for (int i = 1; i <= 3; i++) pulse(32'h320 + 32'(i), 1'b1);
        tick(4);
        chk("t5_pkt", 32'(o_pkt_count), 12);
        chk("t5_fill", 32'(o_fill), 0);
        for (int i = 1; i <= 6; i++) pulse(32'h400 + 32'(i), 1'b1);
        expect_beat(32'h0);
        expect_beat(32'h0);
        i_enable = 1'b0;
        tick(8);
        chk("t4_pkt", 32'(o_pkt_count), 14);
        chk("t4_drain", 32'(sb.size()), 0);
        for (int i = 0; i < 3; i++) pulse(32'h700, 1'b0);
        tick(3);
        chk("t4_idle_drop", 32'(o_drop_count), 0);
        chk("t4_idle_fill", 32'(o_fill), 0);
        chk("t4_idle_valid", 32'(aso_valid), 0);
        i_enable = 1'b1;
        aso_ready = 1'b0;
        tick();
        pulse(32'h501, 1'b0);
        pulse(32'h502, 1'b0);
        chk("t6_pre_fill", 32'(o_fill), 1);
        n_rst = 1'b0;
        exp_beat = 0;
        #1;
        chk("t6_valid", 32'(aso_valid), 0);
        chk("t6_fill", 32'(o_fill), 0);
        chk("t6_pkt", 32'(o_pkt_count), 0);
        chk("t6_drop", 32'(o_drop_count), 0);
        tick(2);
        n_rst = 1'b1;
        aso_ready = 1'b1;
        tick();
        pulse(32'h601, 1'b1);
        chk("t6_sop", 32'(aso_startofpacket), 1);
        chk("t6_data", aso_data, 32'h601);
        tick(4);
        chk("t6_drain", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
